// File: rtl/fb_pkg.sv
// Shared types and widths for the framebuffer scheduler slice.
package fb_pkg;

   localparam int FB_ADDR_W = 19;
   localparam int FB_DATA_W = 4;

   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic [FB_DATA_W-1:0] data;
   } fb_wr_t;

   typedef enum logic {
      RUN     = 1'b0,
      PENDING = 1'b1
   } swap_state_t;

endpackage

// File: rtl/fb_scheduler_if.sv
// Scanout, renderer and RAM signals of the framebuffer scheduler.
// wr_valid/wr_ready: a write transfers in a cycle where both are high; wr_ready never depends on wr_valid.
interface fb_scheduler_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 4
);
   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic [DATA_W-1:0] vga_data;
   logic              vga_valid;
   logic              frame_start;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              swap_req;
   logic              swap_pending;
   logic              front_sel;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W:0]   ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  vga_req, vga_addr, frame_start, wr_valid, wr_addr, wr_data, swap_req, ram_rdata,
      output vga_data, vga_valid, wr_ready, swap_pending, front_sel,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output vga_req, vga_addr, frame_start, wr_valid, wr_addr, wr_data, swap_req, ram_rdata,
      input  vga_data, vga_valid, wr_ready, swap_pending, front_sel,
             ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/fb_wr_fifo.sv
// Renderer write FIFO: power-of-two depth, registered occupancy count, async reset.
module fb_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 23
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q];

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end
endmodule

// File: rtl/fb_scheduler.sv
// Single-port framebuffer access scheduler: scanout reads beat renderer writes,
// and a front/back swap is held off until the write FIFO drains and a frame starts.
module fb_scheduler
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int RAM_LAT    = 1
) (
   input logic          clk,
   input logic          rst,
   fb_scheduler_if.slave bus
);
   swap_state_t       state_q, state_d;
   logic              front_sel_q, front_sel_d;
   logic              ram_en_q, ram_en_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [RAM_LAT:0]  rd_pipe_q;
   logic [DATA_W-1:0] vga_data_q;
   logic              vga_valid;
   fb_wr_t            fifo_din, fifo_dout;
   logic              fifo_full, fifo_empty;
   logic              wr_ready, push, pop;

   assign wr_ready = !fifo_full && (state_q == RUN);
   assign push     = bus.wr_valid && wr_ready;
   assign pop      = !bus.vga_req && !fifo_empty;
   assign fifo_din = '{addr: bus.wr_addr, data: bus.wr_data};

   fb_wr_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fb_wr_t))) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (fifo_din),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if (bus.vga_req) begin
         ram_en_d   = 1'b1;
         ram_addr_d = {front_sel_q, bus.vga_addr};
      end else if (!fifo_empty) begin
         ram_en_d    = 1'b1;
         ram_we_d    = 1'b1;
         ram_addr_d  = {~front_sel_q, fifo_dout.addr};
         ram_wdata_d = fifo_dout.data;
      end
   end

   // Swap only when nothing is left for the old back buffer, at a frame boundary.
   always_comb begin
      state_d     = state_q;
      front_sel_d = front_sel_q;
      case (state_q)
         RUN: begin
            if (bus.swap_req) state_d = PENDING;
         end
         PENDING: begin
            if (bus.frame_start && fifo_empty && !pop) begin
               front_sel_d = ~front_sel_q;
               state_d     = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         front_sel_q <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rd_pipe_q   <= '0;
         vga_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         front_sel_q <= front_sel_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         rd_pipe_q   <= {rd_pipe_q[RAM_LAT-1:0], bus.vga_req};
         if (vga_valid) vga_data_q <= bus.ram_rdata;
      end
   end

   // Return data passes straight through on the valid cycle and is held afterwards.
   assign vga_valid        = rd_pipe_q[RAM_LAT];
   assign bus.vga_valid    = vga_valid;
   assign bus.vga_data     = vga_valid ? bus.ram_rdata : vga_data_q;
   assign bus.wr_ready     = wr_ready;
   assign bus.swap_pending = (state_q == PENDING);
   assign bus.front_sel    = front_sel_q;
   assign bus.ram_en       = ram_en_q;
   assign bus.ram_we       = ram_we_q;
   assign bus.ram_addr     = ram_addr_q;
   assign bus.ram_wdata    = ram_wdata_q;
endmodule

// File: doc/fb_scheduler.md
Name: fb_scheduler

Overview:
- Sequences all accesses to the single-port 4-bit-per-pixel framebuffer RAM.
- Arbitrates between the VGA scanout read path and the renderer write path.
- Manages double buffering as front/back halves of the RAM, with a swap applied only at frame start.
- Sits between the VGA timing/colour path, the renderer and the framebuffer BRAM.

Parameters:
- ADDR_W, 19, pixel address width within one buffer
- DATA_W, 4, pixel (palette index) width
- FIFO_DEPTH, 4, renderer write FIFO entries (power of two, >=2)
- RAM_LAT, 1, RAM read latency in cycles (1 or 2)

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  asynchronous, active-high reset
- vga_req  in  1  scanout read request this cycle
- vga_addr  in  ADDR_W  scanout pixel address
- vga_data  out  DATA_W  read data returned to scanout
- vga_valid  out  1  vga_data valid
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- wr_valid  in  1  renderer write request
- wr_ready  out  1  write accepted when wr_valid&&wr_ready
- wr_addr  in  ADDR_W  renderer pixel address in the back buffer
- wr_data  in  DATA_W  renderer pixel index
- swap_req  in  1  one-cycle pulse: back buffer complete
- swap_pending  out  1  swap requested, not yet applied
- front_sel  out  1  buffer currently scanned out
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W+1  {buffer bit, pixel address}
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (async, active-high) clears all state:
  - vga_valid=0, vga_data=0, swap_pending=0, front_sel=0.
  - FIFO empty, so wr_ready=1.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - Read-valid pipeline cleared.
- Reset mid-operation: queued writes are discarded and a pending swap is cancelled.
- RAM outputs are registered. A decision in cycle N drives the RAM in cycle N+1.
- Arbitration, fixed priority, one access per cycle:
  - vga_req=1: read at {front_sel, vga_addr}; ram_en=1, ram_we=0. The VGA read is never stalled.
  - Otherwise, FIFO non-empty: pop head and write at {~front_sel, addr}; ram_en=1, ram_we=1.
  - Otherwise: ram_en=0.
  - front_sel is sampled in the decision cycle.
- Read return:
  - vga_valid pulses exactly 1+RAM_LAT cycles after the vga_req cycle.
  - vga_data = ram_rdata in that cycle, and holds its value otherwise.
  - Back-to-back requests give back-to-back valids in order.
- Write FIFO:
  - Entry = {addr, data}.
  - wr_ready = !full && !swap_pending. It has no combinational dependence on wr_valid.
  - Push and pop in the same cycle are both allowed, and the count is unchanged.
  - wr_ready is computed from the registered count only, so there is no pass-through when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO order is preserved: a later write to the same address wins.
- Swap FSM, states RUN and PENDING:
  - RUN: swap_req=1 -> PENDING; swap_pending=1 from the next cycle.
  - PENDING:
    - wr_ready=0 and the FIFO drains into the old back buffer.
    - On frame_start with the FIFO empty and no pop in that cycle: toggle front_sel, clear swap_pending, go to RUN.
    - On frame_start with the FIFO non-empty: stay PENDING and wait for the next frame_start.
    - swap_req while PENDING is ignored.
  - swap_req and frame_start in the same RUN cycle: enter PENDING; the swap is applied no earlier than the following frame_start.
  - front_sel changes only in the cycle after a qualifying frame_start, so scanout never tears mid-frame.

Decomposition:
- Shared package fb_pkg holds:
  - FB_ADDR_W=19 and FB_DATA_W=4.
  - The fb_wr_t struct {addr, data}.
  - The swap_state_t enum {RUN, PENDING}.
- One sub-module, fb_wr_fifo: synchronous FIFO with async reset, ports push/pop/full/empty/din/dout.
- Arbiter, read pipeline and swap FSM stay in fb_scheduler.

Test Plan:
- Reset: assert rst mid-burst with 3 queued writes.
  - Required: outputs at reset values; after release wr_ready=1, front_sel=0, no RAM write issued.
- Read latency, RAM_LAT=1: vga_req=1 for 3 cycles, addresses 0, 1, 799; RAM model returns 5, 6, 7.
  - Required: vga_valid high cycles 2-4 after the first request, vga_data 5, 6, 7.
  - Required: ram_addr = {0, addr}.
- Priority: FIFO holds writes (10,3) and (11,4) while vga_req is held high for 20 cycles.
  - Required: no ram_we during those cycles.
  - Required: on the first idle cycles, writes go to {1,10}=3 then {1,11}=4, in order.
- Full/backpressure: push 4 writes with vga_req=1 continuously.
  - Required: wr_ready=0 after the 4th; a 5th wr_valid is not accepted.
  - Required: after vga_req drops, exactly 4 writes are issued.
- Deferred swap: swap_req with 2 entries queued and vga_req=1 continuously; frame_start pulses.
  - Required: swap_pending stays 1 and front_sel stays 0.
  - Required: after the drain, at the next frame_start, front_sel=1 and swap_pending=0.
  - Required: subsequent writes target buffer bit 0.
- Simultaneous swap_req and frame_start with an empty FIFO.
  - Required: no toggle on that pulse; toggle on the next frame_start; a second swap_req while pending has no extra effect.
